// File: rtl/sc_pkg.sv
// Shared constants and state encoding for the stochastic-to-binary counter.
package sc_pkg;

    // Default output width and the matching window length (2^W - 1 samples).
    localparam int unsigned W_DEFAULT = 8;
    localparam int unsigned L_DEFAULT = (32'd1 << W_DEFAULT) - 32'd1;

    // Window length for an arbitrary output width.
    function automatic int unsigned window_len(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sc_sample_counter.sv
// W-bit up-counter with synchronous clear (priority over enable) and a
// terminal flag. The flag is high while the count sits one below TERMINAL,
// so "tc && en" marks the increment that reaches TERMINAL.
module sc_sample_counter
    import sc_pkg::*;
#(
    parameter int unsigned W        = W_DEFAULT,
    parameter int unsigned TERMINAL = L_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] TC_VAL = W'(TERMINAL - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment when enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == TC_VAL);

endmodule

// File: rtl/sc2bin_counter.sv
// Converts a stochastic bitstream to binary by counting ones over a window
// of 2^W - 1 valid samples, then holds the result until accepted.
module sc2bin_counter
    import sc_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         busy,
    output logic [W-1:0] out_value,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned L = window_len(W);

    logic [1:0]   rst_sync_q;
    logic         rst_sync_n;
    state_e       state_q;
    state_e       state_d;
    logic         cnt_clear;
    logic         win_en;
    logic         ones_en;
    logic         out_load;
    logic         win_last;
    logic [W-1:0] ones_count;
    logic [W-1:0] win_count_unused;
    logic         ones_tc_unused;
    logic [W-1:0] out_value_q;
    logic [W-1:0] out_value_d;

    // Reset synchroniser: asserts immediately, releases two edges later.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // Counts every valid sample; its flag marks the L-th one.
    sc_sample_counter #(.W(W), .TERMINAL(L)) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .clear (cnt_clear),
        .en    (win_en),
        .count (win_count_unused),
        .tc    (win_last)
    );

    // Counts the ones among the valid samples; cannot exceed L.
    sc_sample_counter #(.W(W), .TERMINAL(L)) u_ones_cnt (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .clear (cnt_clear),
        .en    (ones_en),
        .count (ones_count),
        .tc    (ones_tc_unused)
    );

    assign ones_en = win_en & bit_in;

    // Next-state and counter control.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        win_en    = 1'b0;
        out_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Abort beats everything, including the final sample.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_valid) begin
                    win_en = 1'b1;
                    if (win_last) begin
                        out_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        cnt_clear = 1'b1;
                        state_d   = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Final count includes the sample taken in the loading cycle; the sum
    // tops out at L, which fits in W bits.
    always_comb begin
        out_value_d = out_value_q;
        if (out_load) begin
            out_value_d = ones_count + W'(bit_in);
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q     <= ST_IDLE;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            out_value_q <= out_value_d;
        end
    end

    assign busy      = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_value = out_value_q;

endmodule

// File: tb/tb_sc2bin_counter.sv
// Self-checking bench for sc2bin_counter: directed windows plus a random
// phase, all compared each cycle against a window-level behavioural model.
module tb_sc2bin_counter;

    localparam int W = 8;
    localparam int L = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic [W-1:0] out_value;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    sc2bin_counter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A window is either open (collecting samples), has a result waiting,
    // or neither. Reset release takes two edges to reach the logic.
    bit m_open     = 0;
    bit m_waiting  = 0;
    int m_samples  = 0;
    int m_ones     = 0;
    int m_result   = 0;
    int m_rst_age  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open = 0; m_waiting = 0; m_samples = 0; m_ones = 0;
            m_result = 0; m_rst_age = 0;
        end else if (m_rst_age < 2) begin
            m_rst_age++;
        end else if (m_open) begin
            if (abort) begin
                m_open = 0;
            end else if (bit_valid) begin
                m_samples++;
                m_ones += int'(bit_in);
                if (m_samples == L) begin
                    m_open    = 0;
                    m_waiting = 1;
                    m_result  = m_ones;
                end
            end
        end else if (m_waiting) begin
            if (out_ready) begin
                m_waiting = 0;
                if (start) begin
                    m_open = 1; m_samples = 0; m_ones = 0;
                end
            end
        end else if (start) begin
            m_open = 1; m_samples = 0; m_ones = 0;
        end
    end

    // Compare every cycle, mid-way between active edges.
    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_open));
        check("out_valid", int'(out_valid), int'(m_waiting));
        check("out_value", int'(out_value), m_result);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; abort = 0; bit_valid = 0; bit_in = 0; out_ready = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
    endtask

    // kind: 0 zeros, 1 ones, 2 random bits, 3 alternating from 1.
    // gaps: 0 none, 1 random, 2 every third cycle idle.
    task automatic feed(input int n_valid, input int kind, input int gaps);
        int got = 0;
        int c = 0;
        bit v;
        bit b;
        while (got < n_valid) begin
            case (gaps)
                1: v = ($urandom_range(3) != 0);
                2: v = ((c % 3) != 2);
                default: v = 1;
            endcase
            case (kind)
                0: b = 0;
                1: b = 1;
                2: b = 1'($urandom);
                default: b = ((got % 2) == 0);
            endcase
            if (!v) b = 1'($urandom);
            bit_valid = v;
            bit_in = b;
            start = 1'($urandom);   // start must be ignored mid-window
            step();
            if (v) got++;
            c++;
        end
        bit_valid = 0;
        start = 0;
    endtask

    task automatic accept();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
        step();
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        quiet();
        step();
        step();
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_value", int'(out_value), 0);
        rst_n = 1;
        step(); step(); step();

        // All ones: result on the cycle after the last sample.
        do_start();
        check("ones_busy_after_start", int'(busy), 1);
        feed(L - 1, 1, 0);
        check("ones_not_valid_early", int'(out_valid), 0);
        feed(1, 1, 0);
        check("ones_valid", int'(out_valid), 1);
        check("ones_value", int'(out_value), 255);
        accept();
        check("ones_idle_after_accept", int'(out_valid), 0);
        check("ones_value_kept_idle", int'(out_value), 255);

        // All zeros, held five cycles without ready.
        do_start();
        feed(L, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("zeros_hold_valid", int'(out_valid), 1);
            check("zeros_hold_value", int'(out_value), 0);
            start = 1;               // ignored while not ready
            bit_valid = 1; bit_in = 1;
            step();
        end
        quiet();
        accept();

        // Alternating 1,0 with every third cycle idle.
        do_start();
        feed(L, 3, 2);
        check("alt_value", int'(out_value), 128);
        accept();

        // Random window, then back-to-back ready+start into a ones window.
        do_start();
        feed(L, 2, 1);
        out_ready = 1; start = 1;
        step();
        quiet();
        check("b2b_busy", int'(busy), 1);
        feed(L, 1, 0);
        check("b2b_value", int'(out_value), 255);
        accept();

        // Abort after 100 samples, then a clean ones window.
        do_start();
        feed(100, 1, 0);
        abort = 1; bit_valid = 1; bit_in = 1;
        step();
        quiet();
        check("abort_idle", int'(busy), 0);
        check("abort_no_valid", int'(out_valid), 0);
        do_start();
        feed(L, 1, 0);
        check("after_abort_value", int'(out_value), 255);
        accept();

        // Abort on the L-th sample wins.
        do_start();
        feed(L - 1, 0, 0);
        abort = 1; bit_valid = 1; bit_in = 1;
        step();
        quiet();
        check("abort_last_no_valid", int'(out_valid), 0);
        check("abort_last_value_kept", int'(out_value), 255);

        // Reset mid-window clears outputs at once.
        do_start();
        feed(50, 1, 0);
        #1 rst_n = 0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_value", int'(out_value), 0);
        @(negedge clk);
        step();
        rst_n = 1;
        step(); step(); step();
        do_start();
        feed(L, 1, 0);
        check("after_rst_value", int'(out_value), 255);

        // Reset while holding a result.
        #1 rst_n = 0;
        #1;
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_value", int'(out_value), 0);
        step();
        rst_n = 1;
        step(); step(); step();

        // Random phase: all inputs random, abort rare.
        for (int i = 0; i < 6000; i++) begin
            start     = ($urandom_range(7) == 0);
            abort     = ($urandom_range(2999) == 0);
            bit_valid = ($urandom_range(4) != 0);
            bit_in    = 1'($urandom);
            out_ready = ($urandom_range(3) == 0);
            step();
        end
        quiet();
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case a step never returns.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
